// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the openframe GPIO configuration chain: loader FSM
// state encoding, counter widths and default chain geometry.
package gpio_cfg_pkg;

    localparam int NUM_PADS_DEFAULT = 44;
    localparam int CFG_BITS_DEFAULT = 13;
    localparam int IDX_W            = 6;
    localparam int PHASE_W          = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_LOAD     = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Bits needed to hold a count running from cfg_bits down to 1.
    function automatic int bit_cnt_width(input int cfg_bits);
        return $clog2(cfg_bits + 1);
    endfunction

endpackage

// File: rtl/gpio_serial_phase_timer.sv
// Phase timer: while run is high, tick fires once every CLK_DIV cycles and the
// count restarts, so back-to-back phases each last exactly CLK_DIV cycles.
module gpio_serial_phase_timer
    import gpio_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(CLK_DIV - 1);

    logic [PHASE_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PHASE_W'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/gpio_serial_loader.sv
// Serial loader for the GPIO pad configuration chain: fetches one word per pad
// (highest index first), shifts it out MSB first, then strobes serial_load.
module gpio_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS = NUM_PADS_DEFAULT,
    parameter int CFG_BITS = CFG_BITS_DEFAULT,
    parameter int CLK_DIV  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                cfg_req,
    output logic [IDX_W-1:0]    cfg_idx,
    input  logic [CFG_BITS-1:0] cfg_word,
    input  logic                cfg_valid,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                busy,
    output logic                done
);

    localparam int BCW = bit_cnt_width(CFG_BITS);

    logic [2:0]          state;
    logic [2:0]          state_n;
    logic [CFG_BITS-1:0] shreg;
    logic [BCW-1:0]      bits_left;
    logic                tick;
    logic                phase_run;
    logic                last_bit;

    assign phase_run = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI) || (state == ST_LOAD);
    assign last_bit  = (bits_left == BCW'(1));

    gpio_serial_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clock (clock),
        .reset (reset),
        .run   (phase_run),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:     if (start) state_n = ST_FETCH;
            ST_FETCH:    if (cfg_valid) state_n = ST_SHIFT_LO;
            ST_SHIFT_LO: if (tick) state_n = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (tick) begin
                    if (!last_bit) begin
                        state_n = ST_SHIFT_LO;
                    end else if (cfg_idx != '0) begin
                        state_n = ST_FETCH;
                    end else begin
                        state_n = ST_LOAD;
                    end
                end
            end
            ST_LOAD:     if (tick) state_n = ST_DONE;
            ST_DONE:     state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    // Pad-facing strobes are registered from the next state so they never
    // glitch while the state register decodes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cfg_req      <= 1'b0;
            serial_clock <= 1'b0;
            serial_load  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            cfg_req      <= (state_n == ST_FETCH);
            serial_clock <= (state_n == ST_SHIFT_HI);
            serial_load  <= (state_n == ST_LOAD);
            busy         <= (state_n == ST_FETCH) || (state_n == ST_SHIFT_LO) ||
                            (state_n == ST_SHIFT_HI) || (state_n == ST_LOAD);
            done         <= (state_n == ST_DONE);
        end
    end

    // The current bit always sits in the MSB; the register only moves on a
    // word load or on the high-to-low edge, so data is stable while clock is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_idx   <= '0;
            shreg     <= '0;
            bits_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) cfg_idx <= IDX_W'(NUM_PADS - 1);
                end
                ST_FETCH: begin
                    if (cfg_valid) begin
                        shreg     <= cfg_word;
                        bits_left <= BCW'(CFG_BITS);
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        if (last_bit) begin
                            if (cfg_idx != '0) cfg_idx <= cfg_idx - IDX_W'(1);
                        end else begin
                            shreg     <= {shreg[CFG_BITS-2:0], 1'b0};
                            bits_left <= bits_left - BCW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign serial_data = shreg[CFG_BITS-1];

endmodule

// File: doc/gpio_serial_loader.md
GPIO_SERIAL_LOADER -- requirements
Module: gpio_serial_loader

Interface
REQ-001 SHALL have parameter NUM_PADS, default 44, giving the number of openframe GPIO pads in the configuration chain.
REQ-002 SHALL have parameter CFG_BITS, default 13, giving the configuration word width per pad.
REQ-003 SHALL have parameter CLK_DIV, default 4 (legal range 1..255), giving the clock cycles per serial_clock phase.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request to load the whole chain.
REQ-007 SHALL have port cfg_req, output, 1 bit: fetch request for one pad's configuration word.
REQ-008 SHALL have port cfg_idx, output, 6 bits: index of the pad being fetched.
REQ-009 SHALL have port cfg_word, input, CFG_BITS bits: configuration word for pad cfg_idx.
REQ-010 SHALL have port cfg_valid, input, 1 bit: cfg_word is valid for the current request.
REQ-011 SHALL have ports serial_clock, serial_data and serial_load, each output, 1 bit: the pad-chain shift clock, data and latch strobe.
REQ-012 SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD and DONE.
REQ-015 SHALL, in IDLE, transition to FETCH on start=1 with cfg_idx set to NUM_PADS-1 and busy=1 from the next cycle.
REQ-016 SHALL ignore start in every state other than IDLE.
REQ-017 SHALL, in FETCH, hold cfg_req=1 and cfg_idx stable until cfg_valid=1 is sampled, then latch cfg_word into a shift register, deassert cfg_req the following cycle and enter SHIFT_LO; the fetch wait is unbounded.
REQ-018 SHALL shift each word MSB first: serial_data = the current bit throughout SHIFT_LO (serial_clock=0, CLK_DIV cycles) and SHIFT_HI (serial_clock=1, CLK_DIV cycles).
REQ-019 SHALL change serial_data only on the transition from SHIFT_HI to SHIFT_LO or from FETCH to SHIFT_LO, never while serial_clock=1.
REQ-020 SHALL, after CFG_BITS bits of a word, decrement cfg_idx and return to FETCH if the finished pad index was nonzero; otherwise it SHALL enter LOAD.
REQ-021 SHALL, in LOAD, drive serial_load=1 and serial_clock=0 for exactly CLK_DIV cycles, then enter DONE.
REQ-022 SHALL, in DONE, assert done=1 for one cycle with busy=0, then return to IDLE.
REQ-023 SHALL, given cfg_valid tied to 1 and start sampled at cycle 0, assert done at cycle NUM_PADS*(1+2*CLK_DIV*CFG_BITS)+CLK_DIV+1.
REQ-024 SHALL count exactly NUM_PADS*CFG_BITS serial_clock rising edges per transfer.
REQ-025 SHALL size the phase counter as 8 bits, the bit counter as ceil(log2(CFG_BITS+1)) bits and cfg_idx as 6 bits, with no wrap inside a transfer.

Reset
REQ-026 SHALL, on reset=1, immediately force state IDLE and drive cfg_req=0, cfg_idx=0, serial_clock=0, serial_data=0, serial_load=0, busy=0 and done=0.
REQ-027 SHALL abort a transfer interrupted by reset without asserting serial_load or done; a later start SHALL restart from pad NUM_PADS-1.

Structure
REQ-028 SHALL take the state encoding and the defaults of NUM_PADS and CFG_BITS from a shared package gpio_cfg_pkg, which is also used by the per-pad receiver.
REQ-029 SHALL be one module with one natural sub-module gpio_serial_phase_timer, which generates the CLK_DIV phase tick.

Verification
REQ-030 SHALL be verified with NUM_PADS=2, CFG_BITS=13, CLK_DIV=1 and cfg_valid tied high: start -> done exactly at cycle 56, and 26 serial_clock rises.
REQ-031 SHALL be verified with pad1=13'h1A5B and pad0=13'h0F0F: the bits captured on serial_clock rises SHALL equal 1A5B MSB-first followed by 0F0F MSB-first.
REQ-032 SHALL be verified with cfg_valid delayed 5 cycles per fetch: serial_clock stays 0, cfg_req stays 1 and cfg_idx stays stable during the wait, and done is delayed by exactly 10 cycles.
REQ-033 SHALL be verified by pulsing start while busy: no restart occurs and the done cycle is unchanged.
REQ-034 SHALL be verified by asserting reset at bit 7 of pad 1: all outputs are 0 in the same cycle and no serial_load occurs; a new start then completes normally.
REQ-035 SHALL be verified with CLK_DIV=4: serial_clock high and low phases are each exactly 4 cycles, and serial_load is high for exactly 4 cycles.
